// File: rtl/button_pkg.sv
// Shared constants and helpers for the push-button
// event front-end.
package button_pkg;

   localparam int N_BTN_DEF      = 4;
   localparam int DEB_CYCLES_DEF = 4;
   localparam int FIFO_DEPTH_DEF = 4;

   function automatic int btn_idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int BTN_IDX_W = btn_idx_w(N_BTN_DEF);

endpackage

// File: rtl/button_event_arbiter_if.sv
// Event handshake between the button front-end
// (master) and its consumer (slave).
interface button_event_arbiter_if
   import button_pkg::*;
#(
   parameter int ID_W = BTN_IDX_W
);

   logic            evt_valid;
   logic            evt_ready;
   logic [ID_W-1:0] evt_id;

   modport master (
      output evt_valid,
      output evt_id,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      output evt_ready
   );

endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stable-level
// debouncer and a one-cycle rise pulse.
module btn_debounce
   import button_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_rise
);

   localparam int CW = $clog2(DEB_CYCLES);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic          r_deb_d;
   logic [CW-1:0] r_cnt;

   // Bring the asynchronous level into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Flip deb after DEB_CYCLES differing samples in a row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb <= 1'b0;
         r_cnt <= '0;
      end else if (r_sync2 == r_deb) begin
         r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
         r_deb <= ~r_deb;
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Delayed copy of deb for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb_d <= 1'b0;
      end else begin
         r_deb_d <= r_deb;
      end
   end

   assign o_rise = r_deb & ~r_deb_d;

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button presses, round-robin arbitrated
// into one event queue with a valid/ready output.
module button_event_arbiter
   import button_pkg::*;
#(
   parameter int N_BTN      = N_BTN_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_BTN-1:0]      btn,
   button_event_arbiter_if.master evt,
   output logic                  evt_drop,
   output logic [N_BTN-1:0]      pending
);

   localparam int IW = btn_idx_w(N_BTN);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [N_BTN-1:0] w_rise;
   logic [N_BTN-1:0] w_grant;
   logic [N_BTN-1:0] w_pend_nxt;
   logic [N_BTN-1:0] r_pending;
   logic             w_found;
   logic [IW-1:0]    w_gidx;
   logic [IW-1:0]    w_scan;
   logic [IW-1:0]    r_rr;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;
   logic             w_drop;
   logic             r_drop;
   logic [IW-1:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_count;

   for (genvar g = 0; g < N_BTN; g++) begin : g_deb
      btn_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_btn  (btn[g]),
         .o_rise (w_rise[g])
      );
   end

   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_valid = (r_count != '0);
   assign w_push  = w_found & ~w_full;
   assign w_pop   = w_valid & evt.evt_ready;

   // First pending button at or after rr, wrapping
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_scan  = r_rr;
      for (int k = 0; k < N_BTN; k++) begin
         if (!w_found && r_pending[w_scan]) begin
            w_found = 1'b1;
            w_gidx  = w_scan;
         end
         if (w_scan == IW'(N_BTN - 1)) begin
            w_scan = '0;
         end else begin
            w_scan = w_scan + IW'(1);
         end
      end
   end

   // A rise re-arms its flag even when granted;
   // a rise on an ungranted set flag is lost
   always_comb begin
      w_grant = '0;
      if (w_push) begin
         w_grant = N_BTN'(1) << w_gidx;
      end
      w_drop     = |(w_rise & r_pending & ~w_grant);
      w_pend_nxt = (r_pending & ~w_grant) | w_rise;
   end

   // Pending flags, round-robin pointer, drop pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_rr      <= '0;
         r_drop    <= 1'b0;
      end else begin
         r_pending <= w_pend_nxt;
         r_drop    <= w_drop;
         if (w_push) begin
            if (w_gidx == IW'(N_BTN - 1)) begin
               r_rr <= '0;
            end else begin
               r_rr <= w_gidx + IW'(1);
            end
         end
      end
   end

   // Circular event queue; no push while full
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem   <= '{default: '0};
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= w_gidx;
            r_wr        <= r_wr + PW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + PW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   assign evt.evt_valid = w_valid;
   assign evt.evt_id    = r_mem[r_rd];
   assign evt_drop      = r_drop;
   assign pending       = r_pending;

endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Front-end input controller for the board push-buttons. It synchronizes and debounces N raw button inputs and turns each debounced press into a one-shot event. A round-robin arbiter shares a single event queue between the buttons. Downstream logic consumes events (button index) over a valid/ready handshake. It replaces per-button one-shot logic wherever several buttons feed one consumer.

## Interface
- N_BTN, 4: number of buttons (≥2).
- DEB_CYCLES, 4: consecutive stable cycles required to accept a level change (≥2; board build uses a larger value).
- FIFO_DEPTH, 4: event queue entries (power of 2).
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  N_BTN  raw asynchronous button levels, 1 = pressed.
- evt_valid  out  1  queue head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_id  out  $clog2(N_BTN)  index of the button for the head event.
- evt_drop  out  1  one-cycle pulse: a press was discarded.
- pending  out  N_BTN  per-button pressed-but-not-yet-queued flags.

## Operation
- Per button: 2-flop synchronizer, then a debouncer with a stable-level register `deb` and a counter.
  - Counter clears whenever the sync output equals `deb`.
  - Otherwise the counter increments; `deb` toggles on the edge where DEB_CYCLES consecutive differing samples have been seen.
- Rising edge of `deb` (registered edge detect) sets `pending[i]`. Falling edges produce nothing.
- Arbiter, each cycle when the queue is not full (registered count < FIFO_DEPTH):
  - Searches `pending` starting at pointer `rr`, ascending modulo N_BTN.
  - The first set bit i is pushed, `pending[i]` clears, and `rr` becomes (i+1) mod N_BTN.
  - No grant means `rr` is unchanged.
- Queue full: no grant; pending flags hold.
- A new rise on button i while `pending[i]` is already set, with no grant to i in that cycle: the press is discarded and `evt_drop` pulses for 1 cycle. Multiple drops in one cycle give a single pulse.
- Grant to i and a new rise on i in the same cycle: `pending[i]` stays set and there is no drop.
- Pop on evt_valid & evt_ready. Push and pop in the same cycle leave the count unchanged. There is no push bypass when full, even if a pop occurs.
- evt_id is stable while evt_valid=1 and not popped.

## Timing
- Reset (async assert): sync flops, `deb`, counters, pending, `rr`=0, queue empty, evt_valid=0, evt_id=0, evt_drop=0. Queued events are discarded.
- Release of reset is synchronous to clk. A button held through reset is seen as a new press once debounced.
- Latency, counting the first edge that samples btn[i]=1 as edge 0 (stable input, empty queue, no competing pending):
  - `deb` rises at edge 1+DEB_CYCLES.
  - `pending[i]` rises at edge 2+DEB_CYCLES.
  - Push and evt_valid=1 occur at edge 3+DEB_CYCLES, which is edge 7 for defaults.
- Throughput: 1 grant/cycle, 1 pop/cycle. All outputs are registered.
- Glitches shorter than DEB_CYCLES cycles at the sync output produce no event.

## Structure
- Shared package `button_pkg`: BTN_IDX_W = $clog2(N_BTN) helper and default constants for DEB_CYCLES and FIFO_DEPTH.
- Sub-module `btn_debounce`: synchronizer, debouncer and rise pulse for one button, instantiated N_BTN times.
- Arbiter, pending flags and circular FIFO (read/write pointers plus count) stay in the top level.

## Test plan
All scenarios use defaults and evt_ready=1 unless stated.
- **Single press:** btn[2] held 10 cycles → exactly one event, evt_id=2, evt_valid asserted at edge 7 for 1 cycle. Release produces no event.
- **Bounce rejection:** btn[0] pattern 1,1,0,1,1,0 then held 1 → exactly one event, id 0, asserted DEB_CYCLES+3 edges after the final stable rise. A 3-cycle pulse alone → no event.
- **Round-robin:** press btn[1] alone and drain it (`rr`=2). Then raise btn[0] and btn[3] on the same edge → ids 3 then 0 on consecutive cycles.
- **Backpressure and drop:**
  - evt_ready=0; press all four buttons → queue holds 0,1,2,3, pending=0.
  - Re-press btn[1] → pending[1]=1.
  - Re-press btn[1] again → evt_drop single pulse, pending unchanged.
  - Set evt_ready=1 → drained ids 0,1,2,3,1, then evt_valid=0.
- **Reset mid-operation:** with 2 events queued and btn[2] held, pull rst_n low → evt_valid=0 and pending=0 immediately, without waiting for a clock. After release → one event id 2 at edge 7 after the first post-reset edge.
